// File: rtl/apu_frame_ctrl.sv
// ---------------------------------------------------------------------------
// apu_frame_ctrl
//   APU frame sequencer controller. It decodes $4017 frame-counter writes and
//   $4015 status reads. It steps the 4-step / 5-step frame pattern and emits
//   the quarter-frame (envelope/linear) and half-frame (length/sweep) clock
//   pulses. It also owns the frame IRQ flag.
//
// Ports
//   iClk          in   APU clock, one edge per APU cycle
//   iReset        in   asynchronous reset, active-high
//   iWrite4017    in   one-cycle $4017 write strobe
//   iData[7:0]    in   write data: [7] mode (1 = 5-step), [6] IRQ inhibit
//   iRead4015     in   one-cycle status-read strobe, clears the frame IRQ
//   oQuarterClk   out  one-cycle quarter-frame pulse
//   oHalfClk      out  one-cycle half-frame pulse
//   oFrameIRQ     out  frame IRQ flag (level)
//   oMode         out  currently applied mode
//   oStep[2:0]    out  current step index (0..4)
//   oWritePending out  a $4017 write is waiting to be applied
// ---------------------------------------------------------------------------
module apu_frame_ctrl #(
  parameter int STEP_PERIOD = 7457,
  parameter int DIV_WIDTH   = 13,
  parameter int WRITE_DELAY = 3
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iWrite4017,
  input  logic [7:0] iData,
  input  logic       iRead4015,
  output logic       oQuarterClk,
  output logic       oHalfClk,
  output logic       oFrameIRQ,
  output logic       oMode,
  output logic [2:0] oStep,
  output logic       oWritePending
);

  localparam int DLY_WIDTH = (WRITE_DELAY < 2) ? 1 : $clog2(WRITE_DELAY + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(STEP_PERIOD - 1);
  localparam logic [DLY_WIDTH-1:0] DLY_LOAD = DLY_WIDTH'(WRITE_DELAY);

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } stepT;

  stepT                 step;
  stepT                 nextStep;
  logic [DIV_WIDTH-1:0] divCnt;
  logic [DLY_WIDTH-1:0] delayCnt;
  logic                 mode;
  logic                 inhibit;
  logic                 irqFlag;
  logic                 quarterClk;
  logic                 halfClk;
  logic                 pending;
  logic                 pendMode;
  logic                 pendInhibit;

  logic                 stepDue;
  logic                 applyNow;
  logic                 decQuarter;
  logic                 decHalf;
  logic                 decIrq;
  logic                 setIrq;
  logic                 clrIrq;

  // Bits 5:0 of $4017 carry no meaning for this block.
  logic                 unusedDataBits;
  assign unusedDataBits = ^iData[5:0];

  assign stepDue  = (divCnt == DIV_LAST);
  // A fresh strobe on the apply edge restarts the delay, so the older write
  // must not land on that same edge.
  assign applyNow = pending && (delayCnt == DLY_WIDTH'(1)) && !iWrite4017;
  assign setIrq   = stepDue && !applyNow && decIrq;
  assign clrIrq   = iRead4015 || (applyNow && pendInhibit);

  // Decode the current (pre-advance) step into pulses, IRQ request and successor.
  always_comb begin
    decQuarter = 1'b0;
    decHalf    = 1'b0;
    decIrq     = 1'b0;
    nextStep   = STEP0;
    case (step)
      STEP0: begin
        decQuarter = 1'b1;
        nextStep   = STEP1;
      end
      STEP1: begin
        decQuarter = 1'b1;
        decHalf    = 1'b1;
        nextStep   = STEP2;
      end
      STEP2: begin
        decQuarter = 1'b1;
        nextStep   = STEP3;
      end
      STEP3: begin
        if (!mode) begin
          decQuarter = 1'b1;
          decHalf    = 1'b1;
          decIrq     = !inhibit;
          nextStep   = STEP0;
        end else begin
          nextStep   = STEP4;
        end
      end
      STEP4: begin
        decQuarter = 1'b1;
        decHalf    = 1'b1;
        nextStep   = STEP0;
      end
      default: begin
        nextStep   = STEP0;
      end
    endcase
  end

  // $4017 write path: latch data, count down the delay, then apply mode/inhibit.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      pending     <= 1'b0;
      pendMode    <= 1'b0;
      pendInhibit <= 1'b0;
      delayCnt    <= '0;
      mode        <= 1'b0;
      inhibit     <= 1'b0;
    end else if (iWrite4017) begin
      pending     <= 1'b1;
      pendMode    <= iData[7];
      pendInhibit <= iData[6];
      delayCnt    <= DLY_LOAD;
    end else if (applyNow) begin
      pending     <= 1'b0;
      delayCnt    <= '0;
      mode        <= pendMode;
      inhibit     <= pendInhibit;
    end else if (pending) begin
      delayCnt    <= delayCnt - DLY_WIDTH'(1);
    end
  end

  // Step divider and sequencer; an applied write restarts the frame and
  // swallows any step event due on the same edge.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      divCnt     <= '0;
      step       <= STEP0;
      quarterClk <= 1'b0;
      halfClk    <= 1'b0;
    end else if (applyNow) begin
      divCnt     <= '0;
      step       <= STEP0;
      quarterClk <= pendMode;
      halfClk    <= pendMode;
    end else if (stepDue) begin
      divCnt     <= '0;
      step       <= nextStep;
      quarterClk <= decQuarter;
      halfClk    <= decHalf;
    end else begin
      divCnt     <= divCnt + DIV_WIDTH'(1);
      quarterClk <= 1'b0;
      halfClk    <= 1'b0;
    end
  end

  // Frame IRQ flag; a set on the same edge as a clear wins.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      irqFlag <= 1'b0;
    end else if (setIrq) begin
      irqFlag <= 1'b1;
    end else if (clrIrq) begin
      irqFlag <= 1'b0;
    end
  end

  assign oQuarterClk   = quarterClk;
  assign oHalfClk      = halfClk;
  assign oFrameIRQ     = irqFlag;
  assign oMode         = mode;
  assign oStep         = step;
  assign oWritePending = pending;

endmodule
